// File: rtl/npu_config_loader.sv
// npu_config_loader
//   Drains the NPU configuration FIFO and decodes header/payload records into
//   weight-memory writes, schedule-memory writes and I/O count registers.
//   One word per cycle; new FIFO reads are held off while the NPU is busy.
//
// Ports
//   CLK                   clock, rising edge
//   RST                   asynchronous active-low reset
//   cfg_fifo_data         FIFO read data, valid the cycle after a pop
//   cfg_fifo_empty        FIFO empty
//   cfg_fifo_read_enable  FIFO pop
//   npu_busy              NPU computing; blocks new pops
//   weight_wr_*           weight memory write port (en, PE id, addr, data)
//   sched_wr_*            schedule memory write port (en, addr, data)
//   num_inputs/outputs    latched I/O counts
//   config_valid          full configuration committed
//   cfg_done              one-cycle pulse on COMMIT
//   cfg_error             sticky error (bad PE id or address overflow)
module npu_config_loader #(
    parameter int unsigned WEIGHT_W = 16,
    parameter int unsigned W_ADDR_W = 8,
    parameter int unsigned SCHED_W  = 24,
    parameter int unsigned S_ADDR_W = 8,
    parameter int unsigned NUM_PE   = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [25:0]         cfg_fifo_data,
    input  logic                cfg_fifo_empty,
    output logic                cfg_fifo_read_enable,
    input  logic                npu_busy,
    output logic                weight_wr_en,
    output logic [7:0]          weight_wr_pe,
    output logic [W_ADDR_W-1:0] weight_wr_addr,
    output logic [WEIGHT_W-1:0] weight_wr_data,
    output logic                sched_wr_en,
    output logic [S_ADDR_W-1:0] sched_wr_addr,
    output logic [SCHED_W-1:0]  sched_wr_data,
    output logic [7:0]          num_inputs,
    output logic [7:0]          num_outputs,
    output logic                config_valid,
    output logic                cfg_done,
    output logic                cfg_error
);

    typedef enum logic [1:0] {
        ST_HEADER    = 2'd0,
        ST_PAYLOAD_W = 2'd1,
        ST_PAYLOAD_S = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_WEIGHTS = 2'b00,
        OP_SCHED   = 2'b01,
        OP_IOCFG   = 2'b10,
        OP_COMMIT  = 2'b11
    } op_t;

    state_t                state_q, state_d;
    logic                  rd_valid_q;
    logic [15:0]           remaining_q, remaining_d;
    logic [7:0]            pe_q, pe_d;
    logic [W_ADDR_W-1:0]   waddr_q, waddr_d;
    logic [S_ADDR_W-1:0]   saddr_q, saddr_d;

    logic                  weight_wr_en_q, weight_wr_en_d;
    logic [7:0]            weight_wr_pe_q, weight_wr_pe_d;
    logic [W_ADDR_W-1:0]   weight_wr_addr_q, weight_wr_addr_d;
    logic [WEIGHT_W-1:0]   weight_wr_data_q, weight_wr_data_d;
    logic                  sched_wr_en_q, sched_wr_en_d;
    logic [S_ADDR_W-1:0]   sched_wr_addr_q, sched_wr_addr_d;
    logic [SCHED_W-1:0]    sched_wr_data_q, sched_wr_data_d;
    logic [7:0]            num_inputs_q, num_inputs_d;
    logic [7:0]            num_outputs_q, num_outputs_d;
    logic                  config_valid_q, config_valid_d;
    logic                  cfg_done_q, cfg_done_d;
    logic                  cfg_error_q, cfg_error_d;

    op_t                   hdr_op;
    logic [7:0]            hdr_target;
    logic [15:0]           hdr_count;
    logic                  pe_in_range;

    // Reads run ahead of decode; every popped word is consumed one cycle later.
    assign cfg_fifo_read_enable = RST & ~cfg_fifo_empty & ~npu_busy;

    assign hdr_op      = op_t'(cfg_fifo_data[25:24]);
    assign hdr_target  = cfg_fifo_data[23:16];
    assign hdr_count   = cfg_fifo_data[15:0];
    assign pe_in_range = ({24'd0, pe_q} < NUM_PE);

    always_comb begin
        state_d          = state_q;
        remaining_d      = remaining_q;
        pe_d             = pe_q;
        waddr_d          = waddr_q;
        saddr_d          = saddr_q;
        weight_wr_en_d   = 1'b0;
        weight_wr_pe_d   = weight_wr_pe_q;
        weight_wr_addr_d = weight_wr_addr_q;
        weight_wr_data_d = weight_wr_data_q;
        sched_wr_en_d    = 1'b0;
        sched_wr_addr_d  = sched_wr_addr_q;
        sched_wr_data_d  = sched_wr_data_q;
        num_inputs_d     = num_inputs_q;
        num_outputs_d    = num_outputs_q;
        config_valid_d   = config_valid_q;
        cfg_done_d       = 1'b0;
        cfg_error_d      = cfg_error_q;

        if (rd_valid_q) begin
            case (state_q)
                ST_HEADER: begin
                    if (hdr_op != OP_COMMIT) begin
                        config_valid_d = 1'b0;
                    end
                    case (hdr_op)
                        OP_WEIGHTS: begin
                            pe_d        = hdr_target;
                            waddr_d     = '0;
                            remaining_d = hdr_count;
                            if ({24'd0, hdr_target} >= NUM_PE) begin
                                cfg_error_d = 1'b1;
                            end
                            if ({16'd0, hdr_count} > (32'd1 << W_ADDR_W)) begin
                                cfg_error_d = 1'b1;
                            end
                            if (hdr_count != '0) begin
                                state_d = ST_PAYLOAD_W;
                            end
                        end
                        OP_SCHED: begin
                            saddr_d     = '0;
                            remaining_d = hdr_count;
                            if ({16'd0, hdr_count} > (32'd1 << S_ADDR_W)) begin
                                cfg_error_d = 1'b1;
                            end
                            if (hdr_count != '0) begin
                                state_d = ST_PAYLOAD_S;
                            end
                        end
                        OP_IOCFG: begin
                            num_inputs_d  = cfg_fifo_data[15:8];
                            num_outputs_d = cfg_fifo_data[7:0];
                        end
                        default: begin
                            config_valid_d = 1'b1;
                            cfg_done_d     = 1'b1;
                        end
                    endcase
                end
                ST_PAYLOAD_W: begin
                    // Out-of-range PE: word is still consumed, but no write issued.
                    if (pe_in_range) begin
                        weight_wr_en_d   = 1'b1;
                        weight_wr_pe_d   = pe_q;
                        weight_wr_addr_d = waddr_q;
                        weight_wr_data_d = cfg_fifo_data[WEIGHT_W-1:0];
                    end
                    waddr_d     = waddr_q + W_ADDR_W'(1);
                    remaining_d = remaining_q - 16'd1;
                    if (remaining_q == 16'd1) begin
                        state_d = ST_HEADER;
                    end
                end
                ST_PAYLOAD_S: begin
                    sched_wr_en_d   = 1'b1;
                    sched_wr_addr_d = saddr_q;
                    sched_wr_data_d = cfg_fifo_data[SCHED_W-1:0];
                    saddr_d         = saddr_q + S_ADDR_W'(1);
                    remaining_d     = remaining_q - 16'd1;
                    if (remaining_q == 16'd1) begin
                        state_d = ST_HEADER;
                    end
                end
                default: begin
                    state_d = ST_HEADER;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q          <= ST_HEADER;
            rd_valid_q       <= 1'b0;
            remaining_q      <= '0;
            pe_q             <= '0;
            waddr_q          <= '0;
            saddr_q          <= '0;
            weight_wr_en_q   <= 1'b0;
            weight_wr_pe_q   <= '0;
            weight_wr_addr_q <= '0;
            weight_wr_data_q <= '0;
            sched_wr_en_q    <= 1'b0;
            sched_wr_addr_q  <= '0;
            sched_wr_data_q  <= '0;
            num_inputs_q     <= '0;
            num_outputs_q    <= '0;
            config_valid_q   <= 1'b0;
            cfg_done_q       <= 1'b0;
            cfg_error_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            rd_valid_q       <= cfg_fifo_read_enable;
            remaining_q      <= remaining_d;
            pe_q             <= pe_d;
            waddr_q          <= waddr_d;
            saddr_q          <= saddr_d;
            weight_wr_en_q   <= weight_wr_en_d;
            weight_wr_pe_q   <= weight_wr_pe_d;
            weight_wr_addr_q <= weight_wr_addr_d;
            weight_wr_data_q <= weight_wr_data_d;
            sched_wr_en_q    <= sched_wr_en_d;
            sched_wr_addr_q  <= sched_wr_addr_d;
            sched_wr_data_q  <= sched_wr_data_d;
            num_inputs_q     <= num_inputs_d;
            num_outputs_q    <= num_outputs_d;
            config_valid_q   <= config_valid_d;
            cfg_done_q       <= cfg_done_d;
            cfg_error_q      <= cfg_error_d;
        end
    end

    assign weight_wr_en   = weight_wr_en_q;
    assign weight_wr_pe   = weight_wr_pe_q;
    assign weight_wr_addr = weight_wr_addr_q;
    assign weight_wr_data = weight_wr_data_q;
    assign sched_wr_en    = sched_wr_en_q;
    assign sched_wr_addr  = sched_wr_addr_q;
    assign sched_wr_data  = sched_wr_data_q;
    assign num_inputs     = num_inputs_q;
    assign num_outputs    = num_outputs_q;
    assign config_valid   = config_valid_q;
    assign cfg_done       = cfg_done_q;
    assign cfg_error      = cfg_error_q;

endmodule

// File: tb/tb_npu_config_loader.sv
// tb_npu_config_loader
//   Directed bench for npu_config_loader. A queue models the config FIFO:
//   a pop at a rising edge presents the word 1 ns later, so the DUT samples
//   it at the following edge. Outputs are sampled on falling edges.
module tb_npu_config_loader;

    logic        CLK;
    logic        RST;
    logic [25:0] cfg_fifo_data;
    logic        cfg_fifo_empty;
    logic        cfg_fifo_read_enable;
    logic        npu_busy;
    logic        weight_wr_en;
    logic [7:0]  weight_wr_pe;
    logic [7:0]  weight_wr_addr;
    logic [15:0] weight_wr_data;
    logic        sched_wr_en;
    logic [7:0]  sched_wr_addr;
    logic [23:0] sched_wr_data;
    logic [7:0]  num_inputs;
    logic [7:0]  num_outputs;
    logic        config_valid;
    logic        cfg_done;
    logic        cfg_error;

    logic [25:0] fifo[$];
    int          checks   = 0;
    int          failures = 0;

    npu_config_loader #(
        .WEIGHT_W (16),
        .W_ADDR_W (8),
        .SCHED_W  (24),
        .S_ADDR_W (8),
        .NUM_PE   (8)
    ) dut (
        .CLK                  (CLK),
        .RST                  (RST),
        .cfg_fifo_data        (cfg_fifo_data),
        .cfg_fifo_empty       (cfg_fifo_empty),
        .cfg_fifo_read_enable (cfg_fifo_read_enable),
        .npu_busy             (npu_busy),
        .weight_wr_en         (weight_wr_en),
        .weight_wr_pe         (weight_wr_pe),
        .weight_wr_addr       (weight_wr_addr),
        .weight_wr_data       (weight_wr_data),
        .sched_wr_en          (sched_wr_en),
        .sched_wr_addr        (sched_wr_addr),
        .sched_wr_data        (sched_wr_data),
        .num_inputs           (num_inputs),
        .num_outputs          (num_outputs),
        .config_valid         (config_valid),
        .cfg_done             (cfg_done),
        .cfg_error            (cfg_error)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (cfg_fifo_read_enable === 1'b1) begin
            #1;
            if (fifo.size() != 0) cfg_fifo_data = fifo.pop_front();
            cfg_fifo_empty = (fifo.size() == 0);
        end
    end

    task automatic push(input logic [25:0] w);
        fifo.push_back(w);
        cfg_fifo_empty = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_reset();
        push(26'h2000000);
        repeat (2) @(negedge CLK);
        checks++;
        if (cfg_fifo_read_enable !== 1'b0) begin
            failures++;
            $display("FAIL reset_rd_en got=%b exp=0", cfg_fifo_read_enable);
        end
        checks++;
        if ({weight_wr_en, weight_wr_pe, weight_wr_addr, weight_wr_data, sched_wr_en,
             sched_wr_addr, sched_wr_data, num_inputs, num_outputs, config_valid,
             cfg_done, cfg_error} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got nonzero exp=all 0 (we=%b se=%b ni=%h cv=%b err=%b)",
                     weight_wr_en, sched_wr_en, num_inputs, config_valid, cfg_error);
        end
        RST = 1'b1;
        #1;
        checks++;
        if (cfg_fifo_read_enable !== 1'b1) begin
            failures++;
            $display("FAIL release_rd_en got=%b exp=1", cfg_fifo_read_enable);
        end
        repeat (4) @(negedge CLK);
        checks++;
        if (cfg_fifo_empty !== 1'b1) begin
            failures++;
            $display("FAIL reset_word_consumed got_empty=%b exp=1", cfg_fifo_empty);
        end
    endtask

    task automatic test_weight_load();
        logic [15:0] exp_data[3];
        exp_data[0] = 16'h0011; exp_data[1] = 16'h0022; exp_data[2] = 16'h0033;
        @(negedge CLK);
        push(26'h0030003); push(26'h11); push(26'h22); push(26'h33);
        for (int i = 1; i <= 7; i++) begin
            @(negedge CLK);
            checks++;
            if (weight_wr_en !== (i >= 3 && i <= 5)) begin
                failures++;
                $display("FAIL wload_en cyc=%0d got=%b exp=%b", i, weight_wr_en, (i >= 3 && i <= 5));
            end
            checks++;
            if (sched_wr_en !== 1'b0) begin
                failures++;
                $display("FAIL wload_no_sched cyc=%0d got=%b exp=0", i, sched_wr_en);
            end
            if (i >= 3 && i <= 5) begin
                checks++;
                if (weight_wr_pe !== 8'd3 || weight_wr_addr !== 8'(i - 3) ||
                    weight_wr_data !== exp_data[i-3]) begin
                    failures++;
                    $display("FAIL wload_write cyc=%0d got pe=%0d addr=%0d data=%h exp pe=3 addr=%0d data=%h",
                             i, weight_wr_pe, weight_wr_addr, weight_wr_data, i - 3, exp_data[i-3]);
                end
            end
        end
    endtask

    task automatic test_iocfg_commit();
        @(negedge CLK);
        push(26'h2000402); push(26'h3000000);
        for (int i = 1; i <= 5; i++) begin
            @(negedge CLK);
            if (i == 2) begin
                checks++;
                if (num_inputs !== 8'd4 || num_outputs !== 8'd2) begin
                    failures++;
                    $display("FAIL iocfg_counts got in=%0d out=%0d exp in=4 out=2", num_inputs, num_outputs);
                end
            end
            checks++;
            if (cfg_done !== (i == 3)) begin
                failures++;
                $display("FAIL commit_done cyc=%0d got=%b exp=%b", i, cfg_done, (i == 3));
            end
            if (i >= 3) begin
                checks++;
                if (config_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL commit_valid cyc=%0d got=%b exp=1", i, config_valid);
                end
            end
        end
        push(26'h1000002); push(26'h00000AA); push(26'h00000BB);
        repeat (2) @(negedge CLK);
        checks++;
        if (config_valid !== 1'b0) begin
            failures++;
            $display("FAIL header_clears_valid got=%b exp=0", config_valid);
        end
        repeat (3) @(negedge CLK);
    endtask

    task automatic test_zero_sched();
        @(negedge CLK);
        push(26'h0010000); push(26'h1000002); push(26'h0ABCDEF); push(26'h0123456);
        for (int i = 1; i <= 7; i++) begin
            @(negedge CLK);
            checks++;
            if (weight_wr_en !== 1'b0) begin
                failures++;
                $display("FAIL zero_no_weight cyc=%0d got=%b exp=0", i, weight_wr_en);
            end
            checks++;
            if (sched_wr_en !== (i == 4 || i == 5)) begin
                failures++;
                $display("FAIL sched_en cyc=%0d got=%b exp=%b", i, sched_wr_en, (i == 4 || i == 5));
            end
            if (i == 4) begin
                checks++;
                if (sched_wr_addr !== 8'd0 || sched_wr_data !== 24'hABCDEF) begin
                    failures++;
                    $display("FAIL sched_w0 got addr=%0d data=%h exp addr=0 data=abcdef", sched_wr_addr, sched_wr_data);
                end
            end
            if (i == 5) begin
                checks++;
                if (sched_wr_addr !== 8'd1 || sched_wr_data !== 24'h123456) begin
                    failures++;
                    $display("FAIL sched_w1 got addr=%0d data=%h exp addr=1 data=123456", sched_wr_addr, sched_wr_data);
                end
            end
        end
    endtask

    task automatic test_busy_stall();
        logic        exp_en;
        logic [7:0]  exp_addr;
        logic [15:0] exp_data;
        @(negedge CLK);
        push(26'h0020004); push(26'h101); push(26'h102); push(26'h103); push(26'h104);
        for (int i = 1; i <= 11; i++) begin
            @(negedge CLK);
            exp_en = 1'b1;
            case (i)
                3:  begin exp_addr = 8'd0; exp_data = 16'h0101; end
                4:  begin exp_addr = 8'd1; exp_data = 16'h0102; end
                9:  begin exp_addr = 8'd2; exp_data = 16'h0103; end
                10: begin exp_addr = 8'd3; exp_data = 16'h0104; end
                default: begin exp_en = 1'b0; exp_addr = 8'd0; exp_data = 16'h0; end
            endcase
            checks++;
            if (weight_wr_en !== exp_en) begin
                failures++;
                $display("FAIL busy_en cyc=%0d got=%b exp=%b", i, weight_wr_en, exp_en);
            end
            if (exp_en) begin
                checks++;
                if (weight_wr_addr !== exp_addr || weight_wr_data !== exp_data || weight_wr_pe !== 8'd2) begin
                    failures++;
                    $display("FAIL busy_write cyc=%0d got pe=%0d addr=%0d data=%h exp pe=2 addr=%0d data=%h",
                             i, weight_wr_pe, weight_wr_addr, weight_wr_data, exp_addr, exp_data);
                end
            end
            if (i >= 4 && i <= 7) begin
                checks++;
                if (cfg_fifo_read_enable !== 1'b0) begin
                    failures++;
                    $display("FAIL busy_rd_en cyc=%0d got=%b exp=0", i, cfg_fifo_read_enable);
                end
            end
            npu_busy = (i >= 3 && i <= 6);
        end
    endtask

    task automatic test_errors();
        int k;
        do_reset();
        checks++;
        if (cfg_error !== 1'b0) begin
            failures++;
            $display("FAIL err_cleared_by_reset got=%b exp=0", cfg_error);
        end
        push(26'h0050101);
        for (int j = 0; j < 257; j++) push(26'(j));
        k = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge CLK);
            if (weight_wr_en === 1'b1) begin
                checks++;
                if (weight_wr_addr !== 8'(k) || weight_wr_data !== 16'(k) || weight_wr_pe !== 8'd5) begin
                    failures++;
                    $display("FAIL wrap_write idx=%0d got pe=%0d addr=%0d data=%h exp pe=5 addr=%0d data=%h",
                             k, weight_wr_pe, weight_wr_addr, weight_wr_data, k % 256, k);
                end
                k++;
            end
        end
        checks++;
        if (k !== 257) begin
            failures++;
            $display("FAIL wrap_count got=%0d exp=257", k);
        end
        checks++;
        if (weight_wr_addr !== 8'd0 || weight_wr_data !== 16'h0100) begin
            failures++;
            $display("FAIL wrap_last got addr=%0d data=%h exp addr=0 data=0100", weight_wr_addr, weight_wr_data);
        end
        checks++;
        if (cfg_error !== 1'b1) begin
            failures++;
            $display("FAIL wrap_error got=%b exp=1", cfg_error);
        end

        do_reset();
        push(26'h0090001); push(26'h00000AB);
        for (int i = 1; i <= 5; i++) begin
            @(negedge CLK);
            checks++;
            if (weight_wr_en !== 1'b0) begin
                failures++;
                $display("FAIL bad_pe_no_write cyc=%0d got=%b exp=0", i, weight_wr_en);
            end
        end
        checks++;
        if (cfg_error !== 1'b1) begin
            failures++;
            $display("FAIL bad_pe_error got=%b exp=1", cfg_error);
        end
        push(26'h2000000);
        repeat (4) @(negedge CLK);
        checks++;
        if (cfg_error !== 1'b1) begin
            failures++;
            $display("FAIL error_sticky got=%b exp=1", cfg_error);
        end
    endtask

    task automatic test_midrecord_reset();
        @(negedge CLK);
        push(26'h0000003); push(26'h0000055);
        repeat (3) @(negedge CLK);
        checks++;
        if (weight_wr_en !== 1'b1 || weight_wr_data !== 16'h0055) begin
            failures++;
            $display("FAIL mid_first_write got en=%b data=%h exp en=1 data=0055", weight_wr_en, weight_wr_data);
        end
        #2;
        RST = 1'b0;
        #1;
        checks++;
        if ({weight_wr_en, weight_wr_pe, weight_wr_addr, weight_wr_data, sched_wr_en,
             sched_wr_addr, sched_wr_data, num_inputs, num_outputs, config_valid,
             cfg_done, cfg_error} !== '0) begin
            failures++;
            $display("FAIL async_reset_outputs got nonzero exp=all 0 (we=%b wd=%h err=%b)",
                     weight_wr_en, weight_wr_data, cfg_error);
        end
        push(26'h2000907);
        @(negedge CLK);
        checks++;
        if (cfg_fifo_read_enable !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_rd_en got=%b exp=0", cfg_fifo_read_enable);
        end
        RST = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge CLK);
            checks++;
            if (weight_wr_en !== 1'b0) begin
                failures++;
                $display("FAIL mid_no_write cyc=%0d got=%b exp=0", i, weight_wr_en);
            end
        end
        checks++;
        if (num_inputs !== 8'd9 || num_outputs !== 8'd7) begin
            failures++;
            $display("FAIL mid_header_after_reset got in=%0d out=%0d exp in=9 out=7", num_inputs, num_outputs);
        end
    endtask

    initial begin
        RST            = 1'b0;
        npu_busy       = 1'b0;
        cfg_fifo_data  = '0;
        cfg_fifo_empty = 1'b1;
        test_reset();
        test_weight_load();
        test_iocfg_commit();
        test_zero_sched();
        test_busy_stall();
        test_errors();
        test_midrecord_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/npu_config_loader.md
Name: npu_config_loader

Overview:
- Consumer end of the NPU configuration stream.
- The host writes 26-bit configuration words into the config FIFO; this block drains that FIFO and decodes header/payload records. It issues write strobes to the PE weight memories and the schedule memory, and latches the I/O counts.
- Sits inside npu between the config FIFO read port and the PE array/scheduler.
- Sustains one word per cycle; stalls while the NPU is computing.

Parameters:
WEIGHT_W, 16, weight payload width (word[WEIGHT_W-1:0])
W_ADDR_W, 8, per-PE weight memory address width (depth 2^W_ADDR_W)
SCHED_W, 24, schedule payload width (word[SCHED_W-1:0])
S_ADDR_W, 8, schedule memory address width
NUM_PE, 8, number of PEs; valid PE ids 0..NUM_PE-1

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  asynchronous, active-low reset
cfg_fifo_data  in  26  config FIFO read data, valid the cycle after a read
cfg_fifo_empty  in  1  config FIFO empty
cfg_fifo_read_enable  out  1  config FIFO pop
npu_busy  in  1  NPU computing; no new reads while high
weight_wr_en  out  1  weight write strobe
weight_wr_pe  out  8  target PE id
weight_wr_addr  out  W_ADDR_W  weight address
weight_wr_data  out  WEIGHT_W  weight value
sched_wr_en  out  1  schedule write strobe
sched_wr_addr  out  S_ADDR_W  schedule address
sched_wr_data  out  SCHED_W  schedule word
num_inputs  out  8  latched input count
num_outputs  out  8  latched output count
config_valid  out  1  full configuration committed
cfg_done  out  1  one-cycle pulse on COMMIT
cfg_error  out  1  sticky error flag

Behaviour:
- Reset (RST low, asynchronous): all outputs 0, state HEADER, remaining count 0, rd_valid 0. cfg_fifo_read_enable is forced 0 while RST is low.
- cfg_fifo_read_enable = ~cfg_fifo_empty & ~npu_busy.
  - It is combinational from registered/inputs only; it is never asserted on empty.
  - Reads run ahead speculatively; every word read is consumed, none dropped.
- rd_valid register = cfg_fifo_read_enable delayed one cycle. A word is "arriving" in the cycle rd_valid=1 and is sampled at that cycle's rising edge.
- Write strobes and latched fields update at the edge that samples the arriving word.
  - Read in cycle t, word arrives in t+1, strobe/outputs visible in cycle t+2.
- Header format: [25:24] op, [23:16] target, [15:0] count.
- States:
  - HEADER: an arriving word is decoded as a header. config_valid clears on any header except COMMIT.
  - op 00 WEIGHTS: pe ← target, addr ← 0, remaining ← count. If count≠0, go to PAYLOAD_W.
  - op 01 SCHED: addr ← 0, remaining ← count. If count≠0, go to PAYLOAD_S.
  - op 10 IOCFG: num_inputs ← word[15:8], num_outputs ← word[7:0]. No payload; stay in HEADER.
  - op 11 COMMIT: config_valid ← 1, cfg_done pulses for 1 cycle. No payload; stay in HEADER.
  - PAYLOAD_W: each arriving word produces weight_wr_en=1 with data=word[WEIGHT_W-1:0], current pe and addr. Then addr++ and remaining--. On remaining reaching 0, return to HEADER.
  - PAYLOAD_S: same pattern on the sched_* outputs.
- Strobes are 0 in any cycle with no arriving payload word; addr/data/pe hold their last values.
- Address wrap: addr wraps modulo 2^ADDR_W. A count > 2^ADDR_W sets cfg_error; writes continue with wrapped addresses.
- PE range: if target ≥ NUM_PE, payload words are consumed but weight_wr_en stays 0, and cfg_error is set.
- cfg_error is cleared only by reset.
- npu_busy:
  - Blocks new reads only.
  - A word read in the cycle before busy rose still arrives and is processed.
  - State and counters hold while busy; processing resumes seamlessly after busy falls.
- Empty mid-record: the loader waits in its PAYLOAD state indefinitely; it has no timeout.
- Reset mid-record: the record is abandoned. After reset, the next arriving word is treated as a header.

Test Plan:
- Reset: hold RST=0 with cfg_fifo_empty=0 -> read_enable=0, all outputs 0. Release RST -> read_enable=1 on the next cycle.
- Weight load: FIFO holds 0x0030003, 0x11, 0x22, 0x33 -> weight_wr_en high for 3 consecutive cycles, starting 2 cycles after the first payload read.
  - pe=3, addr 0/1/2, data 0x0011/0x0022/0x0033; no sched strobe.
- IOCFG+COMMIT: 0x2000402, 0x3000000 -> num_inputs=4, num_outputs=2.
  - cfg_done high exactly one cycle; config_valid=1 held.
  - A subsequent 0x1000002 header clears config_valid.
- Zero count + schedule: 0x0010000, 0x1000002, 0xABCDEF, 0x123456 -> no weight strobe.
  - sched_wr_en at addr 0 (0xABCDEF), then addr 1 (0x123456).
- Busy stall: raise npu_busy after the second weight payload read -> the in-flight word is still written.
  - read_enable=0 while busy; remaining writes resume with correct addr after busy falls; no word lost or duplicated.
- Errors and mid-record reset:
  - Header 0x0090001 (PE 9 ≥ NUM_PE) + 1 payload -> no weight_wr_en, cfg_error=1 until reset.
  - Header count 257 with W_ADDR_W=8 -> the 257th write goes to addr 0 and cfg_error=1.
  - Assert RST mid-payload -> outputs clear immediately, without waiting for a clock edge.
